// File: rtl/odd_parity_frame_rx.sv
// Serial frame receiver: start + 8 data bits (LSB first) + odd parity + stop,
// sampled on bit_en, delivered through a one-deep valid/ready output register.
module odd_parity_frame_rx #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 bit_en,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 par_out,
   output logic                 par_err,
   output logic                 frm_err,
   output logic                 valid,
   input  logic                 ready,
   output logic                 overrun,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e               state_q, state_d;
   logic [2:0]           cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 complete;

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_out_q, par_out_d;
   logic                 par_err_q, par_err_d;
   logic                 frm_err_q, frm_err_d;
   logic                 valid_q, valid_d;
   logic                 overrun_q, overrun_d;

   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      complete = 1'b0;

      if (bit_en) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx) begin
                  state_d = S_DATA;
                  cnt_d   = 3'd0;
               end
            end
            S_DATA: begin
               shift_d[cnt_q] = rx;
               cnt_d          = cnt_q + 3'd1;
               if (cnt_q == 3'(DATA_BITS - 1)) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = rx;
               state_d = S_STOP;
            end
            S_STOP: begin
               complete = 1'b1;
               state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // A completed frame lands only if the slot is empty or being drained this cycle.
   always_comb begin
      data_d    = data_q;
      par_out_d = par_out_q;
      par_err_d = par_err_q;
      frm_err_d = frm_err_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;

      if (complete) begin
         if (!valid_q || ready) begin
            data_d    = shift_q;
            par_out_d = par_q;
            par_err_d = ~(^shift_q ^ par_q);
            frm_err_d = ~rx;
            valid_d   = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= 3'd0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         data_q    <= '0;
         par_out_q <= 1'b0;
         par_err_q <= 1'b0;
         frm_err_q <= 1'b0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         data_q    <= data_d;
         par_out_q <= par_out_d;
         par_err_q <= par_err_d;
         frm_err_q <= frm_err_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_out = data_q;
   assign par_out  = par_out_q;
   assign par_err  = par_err_q;
   assign frm_err  = frm_err_q;
   assign valid    = valid_q;
   assign overrun  = overrun_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_odd_parity_frame_rx.sv
// Bench for odd_parity_frame_rx: directed frames, expected results queued at
// issue time and compared by an independent monitor on each accepted frame.
module tb_odd_parity_frame_rx;

   logic       clk;
   logic       rst_n;
   logic       bit_en;
   logic       rx;
   logic [7:0] data_out;
   logic       par_out;
   logic       par_err;
   logic       frm_err;
   logic       valid;
   logic       ready;
   logic       overrun;
   logic       busy;

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_overrun = 0;

   odd_parity_frame_rx #(.DATA_BITS(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bit_en   (bit_en),
      .rx       (rx),
      .data_out (data_out),
      .par_out  (par_out),
      .par_err  (par_err),
      .frm_err  (frm_err),
      .valid    (valid),
      .ready    (ready),
      .overrun  (overrun),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted frame is compared with the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n && overrun) n_overrun++;
      if (rst_n && valid && ready) begin
         if (sb_q.size() == 0) begin
            check("unexpected_frame", {24'd0, data_out}, 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("data_out", {24'd0, data_out}, {24'd0, e.data});
            check("par_out",  {31'd0, par_out},  {31'd0, e.par});
            check("par_err",  {31'd0, par_err},  {31'd0, e.perr});
            check("frm_err",  {31'd0, frm_err},  {31'd0, e.ferr});
         end
      end
   end

   task automatic strobe(input logic b, input int spacing);
      rx     = b;
      bit_en = 1'b1;
      @(posedge clk); #1;
      bit_en = 1'b0;
      repeat (spacing - 1) begin
         @(posedge clk); #1;
      end
   endtask

   // Issue a full frame; if it is expected to be delivered, queue its result first.
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                             input logic exp_perr, input logic exp_ferr,
                             input int spacing, input bit deliver);
      if (deliver) sb_q.push_back('{data: d, par: p, perr: exp_perr, ferr: exp_ferr});
      strobe(1'b0, spacing);
      for (int i = 0; i < 8; i++) strobe(d[i], spacing);
      strobe(p, spacing);
      strobe(stop, spacing);
      rx = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      bit_en = 1'b0;
      rx     = 1'b1;
      ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_data_out", {24'd0, data_out}, 32'd0);
      check("rst_valid",    {31'd0, valid},    32'd0);
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_flags",    {29'd0, par_out, par_err, frm_err}, 32'd0);
      @(posedge clk); #1;

      // 0xA5, P=1 (5 ones, odd): clean frame, valid for exactly one cycle.
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
      @(negedge clk);
      check("a5_valid_hi", {31'd0, valid}, 32'd1);
      @(negedge clk);
      check("a5_valid_lo", {31'd0, valid}, 32'd0);
      check("a5_hold_data", {24'd0, data_out}, 32'h0000_00A5);

      // 0x07: P=1 gives 4 ones (even) -> error; P=0 gives 3 ones -> ok.
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b1);
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);

      // 0x3C, P=1, stop sampled low -> framing error still delivered.
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1);
      @(negedge clk);
      check("3c_valid", {31'd0, valid}, 32'd1);
      @(posedge clk); #1;

      // Overrun: consumer stalled, second frame dropped.
      ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
      send_frame(8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
      @(negedge clk);
      check("ovr_data_kept", {24'd0, data_out}, 32'h0000_0011);
      check("ovr_valid",     {31'd0, valid},    32'd1);
      check("ovr_pulse",     {31'd0, overrun},  32'd1);
      @(negedge clk);
      check("ovr_pulse_end", {31'd0, overrun},  32'd0);
      @(posedge clk); #1;
      ready = 1'b1;
      @(posedge clk); #1;
      ready = 1'b0;
      @(negedge clk);
      check("ovr_drained", {31'd0, valid}, 32'd0);
      ready = 1'b1;

      // Asynchronous reset after 4 data bits of 0xFF.
      strobe(1'b0, 1);
      for (int i = 0; i < 4; i++) strobe(1'b1, 1);
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_data", {24'd0, data_out}, 32'd0);
      check("async_rst_busy", {31'd0, busy},     32'd0);
      check("async_rst_outs", {27'd0, par_out, par_err, frm_err, valid, overrun}, 32'd0);
      rx = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // 0x80, P=0 (1 one, odd) after reset.
      send_frame(8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b1);

      // rx low without strobes must not start a frame.
      rx = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("no_false_start", {31'd0, busy}, 32'd0);

      // 0x5A, P=1, strobes every third cycle.
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1);

      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      check("sb_empty",      sb_q.size(), 32'd0);
      check("overrun_count", n_overrun,   32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/odd_parity_frame_rx.md
# odd_parity_frame_rx

Serial-to-parallel frame receiver that sits directly upstream of the 8-bit odd parity checker. It samples a serial line on an external bit strobe and assembles start + 8 data bits (LSB first) + odd parity bit + stop bit. It presents the byte and its parity bit in parallel, together with a locally computed parity-error flag and a framing-error flag. Output is held in a one-deep register with a valid/ready handshake.

## Interface
- DATA_BITS, 8, data bits per frame; only 8 is supported. It matches the checker's A0..A7 inputs.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- bit_en  in  1  one-cycle sample strobe, one per bit period; the block samples rx only when this is high.
- rx  in  1  serial line; idle high, start bit low.
- data_out  out  8  received byte; bit 0 is the first data bit received; drives A0..A7 of the checker.
- par_out  out  1  received parity bit; drives P of the checker.
- par_err  out  1  1 when the count of ones in data_out plus par_out is even (odd-parity violation).
- frm_err  out  1  1 when the stop bit was sampled low.
- valid  out  1  data_out, par_out, par_err and frm_err hold a complete frame.
- ready  in  1  consumer accepts the frame on a cycle where valid && ready.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states and transitions; all transitions occur only on cycles with bit_en=1:
  - IDLE: rx=0 → DATA, bit counter cleared to 0. rx=1 → stay in IDLE. There is no glitch filter and no mid-bit start re-check.
  - DATA: the rx value goes into shift register bit[cnt], then cnt increments. After the sample at cnt=7, go to PARITY.
  - PARITY: capture rx as the parity bit, then go to STOP.
  - STOP: sample rx, mark the frame complete, go to IDLE. A new start bit may be detected on the very next bit_en.
- Frame completion is the STOP sample edge:
  - par_err_next = ~(^shift ^ p).
  - frm_err_next = ~rx.
  - If valid=0, or valid && ready in this cycle: load data_out, par_out, par_err and frm_err from the *_next values; valid=1.
  - If valid=1 and ready=0: keep the old frame, discard the new one, pulse overrun for one cycle.
- Handshake:
  - valid && ready with no completion in the same cycle → valid=0 on the next edge.
  - Output registers keep their last value after valid drops.
  - Outputs change only on a load.
- Flags are reported and never block delivery. A frame with par_err=1 or frm_err=1 is still presented with valid=1.
- Reset values: data_out=0, par_out=0, par_err=0, frm_err=0, valid=0, overrun=0, busy=0; FSM=IDLE; counter=0; shift=0.

## Timing
- A frame takes 11 bit_en strobes. Strobes may be on consecutive cycles or arbitrarily spaced. Cycles with bit_en=0 change no state except handshake consumption.
- Latency: valid and all frame outputs are updated by the same edge that samples the stop bit; they are visible the following cycle.
- busy rises the edge after the start-bit sample and falls the edge after the stop sample.
- Back-to-back frames: completion and consume in the same cycle → valid stays high, new data is loaded, no overrun.
- Reset mid-frame (async): all outputs go to reset values immediately and the partial frame is lost. After rst_n release, the block waits in IDLE for a start bit.
- rx is assumed synchronous to clk. Any synchronizer is outside this block.

## Test plan
- Frame 0xA5 (LSB first 1,0,1,0,0,1,0,1), P=1, stop=1, ready=1, bit_en every cycle → valid pulses 1 cycle with data_out=0xA5, par_out=1, par_err=0, frm_err=0; overrun stays 0.
- Frame 0x07 with P=1 (even total of ones) → par_err=1, frm_err=0, data_out=0x07. Frame 0x07 with P=0 → par_err=0.
- Frame 0x3C, P=1, stop bit sampled 0 → frm_err=1, par_err=0, valid=1.
- ready=0, frames 0x11 then 0x22 → after the second stop sample: data_out=0x11, valid=1, overrun high for exactly 1 cycle. Then ready=1 for 1 cycle → valid=0.
- rst_n asserted after 4 data bits of 0xFF → all outputs 0 and busy=0 immediately. After release, frame 0x80, P=0 → data_out=0x80, par_err=0.
- Frame 0x5A, P=1 with bit_en every 3 cycles, and rx held low in IDLE without bit_en for 10 cycles beforehand → no false start; result is identical to the every-cycle case.
